// File: rtl/edf_arbiter.sv
// Earliest-deadline-first arbiter: one pending slot per requester, IDLE -> GRANT -> RELEASE grant cycle.
// Optional feature macro: EDF_DEADLINE_AGING_EN (pending deadlines count down by one per cycle, saturating at 0).
module edf_arbiter #(
  parameter int NB_REQUESTERS  = 4,
  parameter int DEADLINE_WIDTH = 8
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NB_REQUESTERS-1:0]                      req_valid,
  input  logic [NB_REQUESTERS-1:0][DEADLINE_WIDTH-1:0]  req_deadline,
  output logic [NB_REQUESTERS-1:0]                      req_ready,
  output logic [$clog2(NB_REQUESTERS)-1:0]              out_index,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [1:0]                                    dbg_state,
  output logic [NB_REQUESTERS-1:0][DEADLINE_WIDTH-1:0]  dbg_deadline
);
  localparam int IW = $clog2(NB_REQUESTERS);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

  state_t                                        state_q, state_d;
  logic [NB_REQUESTERS-1:0]                      pending, accept, clear;
  logic [NB_REQUESTERS-1:0][DEADLINE_WIDTH-1:0]  deadline;
  logic                                          grant_load, grant_done;
  logic [IW-1:0]                                 win_idx;
  logic [DEADLINE_WIDTH-1:0]                     win_dl;
  logic                                          win_found;

  // Handshakes: a transfer happens on a rising edge where valid && ready; req side
  // moves a deadline into its slot, out side retires the granted slot.
  assign req_ready    = ~pending;
  assign accept       = req_valid & req_ready;
  assign out_valid    = (state_q == GRANT);
  assign dbg_state    = state_q;
  assign dbg_deadline = deadline;

  // Strict less-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    win_idx   = '0;
    win_dl    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NB_REQUESTERS; i++) begin
      if (pending[i] && (!win_found || deadline[i] < win_dl)) begin
        win_found = 1'b1;
        win_dl    = deadline[i];
        win_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    grant_done = 1'b0;
    clear      = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d    = GRANT;
          grant_load = 1'b1;
        end
      end
      GRANT: begin
        if (out_ready) begin
          state_d          = RELEASE;
          grant_done       = 1'b1;
          clear[out_index] = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_index <= '0;
    end else begin
      state_q <= state_d;
      if (grant_load) out_index <= win_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      deadline <= '0;
    end else begin
      for (int i = 0; i < NB_REQUESTERS; i++) begin
        if (accept[i]) begin
          pending[i]  <= 1'b1;
          deadline[i] <= req_deadline[i];
        end else begin
          if (clear[i]) pending[i] <= 1'b0;
`ifdef EDF_DEADLINE_AGING_EN
          // Aging continues while the slot is granted; only acceptance edges skip it.
          if (pending[i] && deadline[i] != '0)
            deadline[i] <= deadline[i] - DEADLINE_WIDTH'(1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_edf_arbiter.sv
// Self-checking bench for edf_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural EDF model.
module tb_edf_arbiter;
  localparam int NB = 4;
  localparam int DW = 8;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NB-1:0]         req_valid = '0;
  logic [NB-1:0][DW-1:0] req_deadline = '0;
  logic [NB-1:0]         req_ready;
  logic [1:0]            out_index;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [1:0]            dbg_state;
  logic [NB-1:0][DW-1:0] dbg_deadline;

  int checks = 0;
  int errors = 0;

  // Reference model: pending flags, deadlines, current grant and post-grant gap.
  bit          m_pending[NB];
  logic [7:0]  m_deadline[NB];
  bit          m_valid;
  int          m_idx;
  int          m_gap;
  logic [1:0]  exp_q[$];

  edf_arbiter #(.NB_REQUESTERS(NB), .DEADLINE_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_deadline(req_deadline),
    .req_ready(req_ready), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state), .dbg_deadline(dbg_deadline)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_pending[i]  = 1'b0;
      m_deadline[i] = '0;
    end
    m_valid = 1'b0;
    m_idx   = 0;
    m_gap   = 0;
  endfunction

  function automatic logic [NB-1:0] model_ready();
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = !m_pending[i];
    return r;
  endfunction

  // Advance the model by one edge using the inputs now applied, then step the DUT.
  task automatic tick();
    bit acc[NB];
    bit old_p[NB];
    int best;
    for (int i = 0; i < NB; i++) begin
      old_p[i] = m_pending[i];
      acc[i]   = req_valid[i] && !m_pending[i];
    end
    if (m_valid) begin
      if (out_ready) begin
        m_pending[m_idx] = 1'b0;
        m_valid = 1'b0;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      best = -1;
      for (int i = 0; i < NB; i++)
        if (old_p[i] && (best < 0 || m_deadline[i] < m_deadline[best])) best = i;
      if (best >= 0) begin
        m_valid = 1'b1;
        m_idx   = best;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (acc[i]) begin
        m_pending[i]  = 1'b1;
        m_deadline[i] = req_deadline[i];
      end
`ifdef EDF_DEADLINE_AGING_EN
      else if (old_p[i] && m_deadline[i] != 0) m_deadline[i] = m_deadline[i] - 8'd1;
`endif
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_req_ready got %b exp 1111", req_ready); end
    checks++;
    if (out_index !== 2'd0) begin errors++; $display("FAIL reset_out_index got %0d exp 0", out_index); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_deadline[2] = 8'd10;
    tick();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b1011 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_accept ready=%b valid=%b exp ready=1011 valid=0", req_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd2) begin
      errors++; $display("FAIL single_grant valid=%b idx=%0d exp valid=1 idx=2", out_valid, out_index);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL single_release valid=%b ready2=%b exp valid=0 ready2=1", out_valid, req_ready[2]);
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_order();
    int last = -1;
    int grants = 0;
    exp_q = '{2'd1, 2'd3, 2'd2, 2'd0};
    req_deadline = {8'd5, 8'd20, 8'd5, 8'd40};
    req_valid = 4'b1111;
    tick();
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        grants++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL order_extra_grant idx=%0d at cycle %0d", out_index, c);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (out_index !== e) begin errors++; $display("FAIL order_idx got %0d exp %0d", out_index, e); end
        end
        checks++;
        if ((last < 0 && c != 1) || (last >= 0 && c - last != 3)) begin
          errors++; $display("FAIL order_spacing grant at cycle %0d previous %0d", c, last);
        end
        last = c;
      end
    end
    checks++;
    if (grants != 4) begin errors++; $display("FAIL order_count got %0d exp 4", grants); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    req_valid = 4'b0001;
    req_deadline[0] = 8'd7;
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin req_valid = 4'b0010; req_deadline[1] = 8'd1; end
      tick();
      req_valid = '0;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 2'd0) begin
        errors++; $display("FAIL stall_hold c=%0d valid=%b idx=%0d exp valid=1 idx=0", c, out_valid, out_index);
      end
    end
    checks++;
    if (req_ready !== 4'b1100) begin errors++; $display("FAIL stall_pending ready=%b exp 1100", req_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd1) begin
      errors++; $display("FAIL stall_next valid=%b idx=%0d exp valid=1 idx=1", out_valid, out_index);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    req_valid = 4'b1000;
    req_deadline[3] = 8'd9;
    tick();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre valid=%b exp 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b1111) begin
      errors++; $display("FAIL areset_now valid=%b ready=%b exp valid=0 ready=1111", out_valid, req_ready);
    end
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_no_grant c=%0d valid=%b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_aging();
    req_valid = 4'b0001;
    req_deadline[0] = 8'd3;
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b0010;
    req_deadline[1] = 8'd2;
    tick();
    req_valid = '0;
`ifdef EDF_DEADLINE_AGING_EN
    checks++;
    if (dbg_deadline[0] !== 8'd0 || dbg_deadline[1] !== 8'd2) begin
      errors++; $display("FAIL aging_values d0=%0d d1=%0d exp d0=0 d1=2", dbg_deadline[0], dbg_deadline[1]);
    end
`else
    checks++;
    if (dbg_deadline[0] !== 8'd3 || dbg_deadline[1] !== 8'd2) begin
      errors++; $display("FAIL aging_values d0=%0d d1=%0d exp d0=3 d1=2", dbg_deadline[0], dbg_deadline[1]);
    end
`endif
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd0) begin
      errors++; $display("FAIL aging_grant0 valid=%b idx=%0d exp valid=1 idx=0", out_valid, out_index);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd1) begin
      errors++; $display("FAIL aging_grant1 valid=%b idx=%0d exp valid=1 idx=1", out_valid, out_index);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NB; i++) req_deadline[i] = 8'($urandom_range(0, 12));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (out_valid !== m_valid || req_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ctrl c=%0d valid=%b ready=%b exp valid=%b ready=%b",
                           c, out_valid, req_ready, m_valid, model_ready());
      end
      if (m_valid) begin
        checks++;
        if (int'(out_index) !== m_idx) begin
          errors++; $display("FAIL rand_idx c=%0d got %0d exp %0d", c, out_index, m_idx);
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (m_pending[i]) begin
          checks++;
          if (dbg_deadline[i] !== m_deadline[i]) begin
            errors++; $display("FAIL rand_deadline c=%0d slot %0d got %0d exp %0d", c, i, dbg_deadline[i], m_deadline[i]);
          end
        end
      end
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (16) tick();
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b1111) begin
      errors++; $display("FAIL rand_drain valid=%b ready=%b exp valid=0 ready=1111", out_valid, req_ready);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_stall();
    test_async_reset();
    test_aging();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edf_arbiter.md
EDF_ARBITER -- requirements
Module: edf_arbiter

Interface
REQ-001 Parameter NB_REQUESTERS, 4, number of requesters and selector inputs; fixed at 4.
REQ-002 Parameter DEADLINE_WIDTH, 8, bit width of each deadline value.
REQ-003 clock  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 req_valid  input  4  per-requester request strobe.
REQ-006 req_deadline  input  4x8  per-requester relative deadline, sampled on acceptance.
REQ-007 req_ready  output  4  per-requester slot free; req_ready[i] = !pending[i].
REQ-008 out_index  output  2  index driven to the Selector's index input.
REQ-009 out_valid  output  1  out_index holds a granted requester.
REQ-010 out_ready  input  1  downstream consumed the selected value.

Function
REQ-011 Each requester SHALL own one pending slot: a pending bit plus a DEADLINE_WIDTH deadline register.
REQ-012 Acceptance SHALL occur at an edge where req_valid[i] && req_ready[i]: set pending[i] and load deadline[i] from req_deadline[i].
REQ-013 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-014 In IDLE with any pending bit set, the next edge SHALL latch the winner into out_index, set out_valid=1 and enter GRANT.
REQ-015 The winner SHALL be the pending slot with the smallest deadline; ties SHALL go to the lowest index.
REQ-016 A request accepted at edge N into an idle arbiter SHALL produce out_valid=1 after edge N+1; same-edge arrivals are not eligible until the next edge.
REQ-017 In GRANT, out_index and out_valid SHALL stay stable until out_ready=1 is sampled.
REQ-018 At the GRANT edge with out_ready=1: clear pending[out_index], drive out_valid to 0 and enter RELEASE.
REQ-019 RELEASE SHALL last exactly one cycle and then return to IDLE; the minimum grant period is 3 cycles.
REQ-020 A slot cleared at edge N SHALL show req_ready high after edge N, and SHALL accept a new request at edge N+1 at the earliest.
REQ-021 Deadline comparison SHALL be unsigned over DEADLINE_WIDTH bits.
REQ-022 With no pending slot, the FSM SHALL remain in IDLE with out_valid=0 and out_index unchanged.
REQ-023 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-024 While reset=0, regardless of clock, the block SHALL force: pending=0, all deadlines=0, state=IDLE, out_valid=0, out_index=0, req_ready=4'b1111.
REQ-025 Reset asserted during GRANT SHALL drop out_valid immediately and discard every pending request.
REQ-026 On reset release, acceptance SHALL resume at the first rising edge.

Configuration
REQ-027 Macro EDF_DEADLINE_AGING_EN SHALL control deadline aging.
REQ-028 When defined, every pending slot's deadline SHALL decrement by 1 each cycle, saturating at 0.
REQ-029 When defined, a slot's deadline SHALL not decrement on its acceptance edge.
REQ-030 When defined, a slot's deadline SHALL keep decrementing while that slot is granted.
REQ-031 When not defined, deadlines SHALL stay at their loaded value until the slot is cleared.

Verification
REQ-032 Reset, then a single request on requester 2, deadline 10 -> out_valid=1, out_index=2 one edge after acceptance; out_ready=1 -> out_valid=0, req_ready[2]=1.
REQ-033 Simultaneous requests with deadlines {40,5,20,5} -> grant order 1, 3, 2, 0, each grant 3 cycles apart with out_ready held at 1.
REQ-034 Grant on requester 0 with out_ready=0 for 5 cycles -> out_index=0 and out_valid=1 stable throughout; requester 1's new request is held pending until the grant completes.
REQ-035 reset=0 asserted mid-GRANT between clock edges -> out_valid=0 and req_ready=4'b1111 without waiting for a clock edge; no grant after release until a new request arrives.
REQ-036 With EDF_DEADLINE_AGING_EN: requester 0 deadline 3 accepted, requester 1 deadline 2 accepted 3 cycles later while requester 0 is stalled in GRANT -> requester 0 ages to 0 (saturates) and is still granted before requester 1. Without the macro -> the deadline registers read back as 3 and 2.
